mu_memory_master: RTL and testbench
===================================

MU_MEMORY_MASTER -- requirements
Module: MU_MemoryMaster

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32 (package value): data and address width.
REQ-002 SHALL have parameter ADDR_BASE, default 32'h1001_0000: byte address of memory word 0.
REQ-003 SHALL have parameter MEM_WORDS, default 64: number of words in the attached memory unit.
REQ-004 SHALL have parameter READ_LATENCY, default 1, legal range 0..3: cycles from address issue to valid mem_rd_i.
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port req_valid_i, input, 1: core request valid.
REQ-008 SHALL have port req_ready_o, output, 1: block can accept a request.
REQ-009 SHALL have port req_we_i, input, 1: 1 = store, 0 = load.
REQ-010 SHALL have port req_addr_i, input, DATA_WIDTH: byte address.
REQ-011 SHALL have port req_wdata_i, input, DATA_WIDTH: store data.
REQ-012 SHALL have port rsp_valid_o, output, 1: response valid.
REQ-013 SHALL have port rsp_ready_i, input, 1: core accepts the response.
REQ-014 SHALL have port rsp_rdata_o, output, DATA_WIDTH: load data (0 for stores and errors).
REQ-015 SHALL have port rsp_err_o, output, 1: misaligned or out-of-range access.
REQ-016 SHALL have port mem_we_o, output, 1: memory unit write enable.
REQ-017 SHALL have port mem_wd_o, output, DATA_WIDTH: memory unit write data.
REQ-018 SHALL have port mem_addr_o, output, DATA_WIDTH: memory unit word index.
REQ-019 SHALL have port mem_rd_i, input, DATA_WIDTH: memory unit read data.

Function
REQ-020 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; req_ready_o = 1 only in IDLE.
REQ-021 IDLE: on req_valid_i && req_ready_o at an edge, SHALL latch we, addr, wdata and leave IDLE; otherwise remain.
REQ-022 Error check at acceptance: misaligned = addr[1:0] != 0; out of range = addr < ADDR_BASE or (addr - ADDR_BASE) >> 2 >= MEM_WORDS (unsigned, DATA_WIDTH bits).
REQ-023 On error SHALL go IDLE -> RESP with rsp_err_o = 1, rsp_rdata_o = 0; no ISSUE, mem_we_o never asserted.
REQ-024 On no error SHALL go IDLE -> ISSUE.
REQ-025 ISSUE lasts exactly one cycle: mem_addr_o = (addr - ADDR_BASE) >> 2, mem_wd_o = latched wdata, mem_we_o = latched we.
REQ-026 mem_we_o, mem_wd_o, mem_addr_o SHALL be registered outputs; mem_we_o = 0 in every state except ISSUE of a store; mem_wd_o = 0 outside ISSUE.
REQ-027 Store: ISSUE -> RESP; rsp_rdata_o = 0, rsp_err_o = 0.
REQ-028 Load, READ_LATENCY = 0: capture mem_rd_i at the end of ISSUE, then go to RESP.
REQ-029 Load, READ_LATENCY = L > 0: ISSUE -> WAIT for exactly L cycles (down-counter); capture mem_rd_i at the end of the last WAIT cycle, then go to RESP.
REQ-030 mem_addr_o SHALL hold the word index during WAIT.
REQ-031 rsp_valid_o = 1 only in RESP, in cycle ISSUE+L+1 for loads and ISSUE+1 for stores.
REQ-032 RESP: rsp_rdata_o and rsp_err_o SHALL hold stable while rsp_valid_o && !rsp_ready_i.
REQ-033 RESP: on rsp_ready_i SHALL go RESP -> IDLE; the next request is accepted no earlier than the following cycle (no overlap).
REQ-034 req_valid_i outside IDLE SHALL be ignored and causes no state change.
REQ-035 rsp_rdata_o SHALL be cleared to 0 on entering RESP for stores and errors.

Reset
REQ-036 rst_n low SHALL immediately force state IDLE, the counter to 0, and all latched request fields to 0.
REQ-037 rst_n low SHALL immediately force rsp_valid_o = 0, rsp_err_o = 0, rsp_rdata_o = 0, mem_we_o = 0, mem_wd_o = 0, mem_addr_o = 0, and req_ready_o = 1.
REQ-038 Reset mid-operation (ISSUE, WAIT or RESP) SHALL abort the transaction: no response, and mem_we_o deasserted asynchronously.

Verification (ADDR_BASE = 0x10010000, MEM_WORDS = 64, READ_LATENCY = 1, memory model with registered read)
REQ-039 Store 0x10010008 / 0xDEADBEEF -> one cycle with mem_we_o = 1, mem_addr_o = 2, mem_wd_o = 0xDEADBEEF; rsp_valid_o next cycle with err = 0, rdata = 0.
REQ-040 Load 0x10010008 after REQ-039 -> mem_we_o stays 0; rsp_valid_o in cycle ISSUE+2 with rsp_rdata_o = 0xDEADBEEF.
REQ-041 Load 0x10010002, 0x10010100 and 0x1000FFFC -> each gives rsp_err_o = 1, rdata = 0, response the cycle after acceptance, and no memory access.
REQ-042 Load word 63 (0x100100FC) with rsp_ready_i low for 5 cycles -> rsp_valid_o and rdata held; req_ready_o = 0; concurrent req_valid_i ignored; IDLE the cycle after rsp_ready_i.
REQ-043 rst_n pulsed low during WAIT -> all outputs 0 immediately except req_ready_o = 1; no response afterwards; next store accepted normally.

Source files
------------

// File: rtl/mu_memory_master.sv
// Core-side load/store master for a word-addressed memory unit with fixed read latency.
// One outstanding request at a time; range/alignment errors are answered without a memory access.
module mu_memory_master #(
  parameter int unsigned              DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0]    ADDR_BASE    = 32'h1001_0000,
  parameter int unsigned              MEM_WORDS    = 64,
  parameter int unsigned              READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_wd_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_rd_i
);

  // WAIT runs for cnt = LatM1 down to 0, i.e. exactly READ_LATENCY cycles.
  localparam logic [1:0] LatM1 = 2'((READ_LATENCY == 0) ? 0 : READ_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0] mem_wd_q, mem_wd_d;
  logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;

  logic [DATA_WIDTH-1:0] req_off;
  logic [DATA_WIDTH-1:0] req_idx;
  logic                  req_err;

  assign req_off = req_addr_i - ADDR_BASE;
  assign req_idx = req_off >> 2;
  assign req_err = (req_addr_i[1:0] != 2'b00) || (req_addr_i < ADDR_BASE) ||
                   (req_idx >= DATA_WIDTH'(MEM_WORDS));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) state_d = req_err ? StResp : StIssue;
      end
      StIssue: begin
        if (we_q || (READ_LATENCY == 0)) state_d = StResp;
        else                              state_d = StWait;
      end
      StWait: begin
        if (cnt_q == 2'd0) state_d = StResp;
      end
      StResp: begin
        if (rsp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output and datapath next-value logic
  always_comb begin
    req_ready_o = (state_q == StIdle);
    rsp_valid_o = (state_q == StResp);
    we_d        = we_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    mem_we_d    = 1'b0;
    mem_wd_d    = '0;
    mem_addr_d  = mem_addr_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          we_d = req_we_i;
          if (req_err) begin
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            // Memory strobes are registered so they are live throughout ISSUE.
            mem_we_d   = req_we_i;
            mem_wd_d   = req_wdata_i;
            mem_addr_d = req_idx;
          end
        end
      end
      StIssue: begin
        cnt_d = LatM1;
        if (we_q)                    rdata_d = '0;
        else if (READ_LATENCY == 0)  rdata_d = mem_rd_i;
      end
      StWait: begin
        if (cnt_q == 2'd0) rdata_d = mem_rd_i;
        else               cnt_d   = cnt_q - 2'd1;
      end
      StResp: begin
        if (rsp_ready_i) begin
          err_d   = 1'b0;
          rdata_d = '0;
          we_d    = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      mem_we_q   <= 1'b0;
      mem_wd_q   <= '0;
      mem_addr_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      mem_we_q   <= mem_we_d;
      mem_wd_q   <= mem_wd_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign mem_we_o    = mem_we_q;
  assign mem_wd_o    = mem_wd_q;
  assign mem_addr_o  = mem_addr_q;

endmodule

// File: tb/tb_mu_memory_master.sv
// Bench for mu_memory_master: transaction-timeline reference model checked every cycle,
// directed literal cases and randomized load/store traffic against a registered-read memory.
`timescale 1ns/1ps
module tb_mu_memory_master;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int unsigned WORDS = 64;
  localparam int unsigned LAT   = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_we_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        rsp_ready_i = 1'b0;
  logic        req_ready_o, rsp_valid_o, rsp_err_o, mem_we_o;
  logic [31:0] rsp_rdata_o, mem_wd_o, mem_addr_o, mem_rd_q;

  logic [31:0] mem_arr [WORDS];
  logic [31:0] gold    [WORDS];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;

  // Reference model: one transaction described by its cycle timeline.
  bit          m_busy;
  bit          m_we;
  bit          m_err;
  int          m_issue;
  int          m_resp_from;
  int          m_idx;
  logic [31:0] m_wd;
  logic [31:0] m_rdata;

  // Per-transaction observations from the driver.
  logic [31:0] t_rd, t_first_addr, t_first_wd;
  bit          t_err, t_first_we, t_any_we;
  int          t_lat;

  mu_memory_master #(
    .DATA_WIDTH  (32),
    .ADDR_BASE   (BASE),
    .MEM_WORDS   (WORDS),
    .READ_LATENCY(LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_we_i   (req_we_i),
    .req_addr_i (req_addr_i),
    .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o  (rsp_err_o),
    .mem_we_o   (mem_we_o),
    .mem_wd_o   (mem_wd_o),
    .mem_addr_o (mem_addr_o),
    .mem_rd_i   (mem_rd_q)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    return (32'(i) + 32'd1) * 32'h9E37_79B9 ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit model_err(logic [31:0] a);
    longint unsigned off;
    if (a % 4 != 0) return 1'b1;
    if (a < BASE) return 1'b1;
    off = 64'(a) - 64'(BASE);
    return (off / 4) >= 64'(WORDS);
  endfunction

  function automatic int word_of(logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 5))
      0:       a = BASE + 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
      1:       a = BASE + 32'($urandom_range(64, 300)) * 4;
      2:       a = BASE - 32'($urandom_range(1, 100)) * 4;
      default: a = BASE + 32'($urandom_range(0, 63)) * 4;
    endcase
    return a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Attached memory unit with registered read.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(WORDS); i++) mem_arr[i] <= init_word(i);
      mem_rd_q <= '0;
    end else begin
      if (mem_we_o) mem_arr[mem_addr_o[5:0]] <= mem_wd_o;
      mem_rd_q <= mem_arr[mem_addr_o[5:0]];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Model update: acceptance edge n -> ISSUE at n, response from n+1 (store), n+1+LAT (load),
  // or n (error); response retires on the first edge that sees rsp_ready.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy      <= 1'b0;
      m_we        <= 1'b0;
      m_err       <= 1'b0;
      m_issue     <= -1;
      m_resp_from <= 0;
      m_idx       <= 0;
      m_wd        <= '0;
      m_rdata     <= '0;
      for (int i = 0; i < int'(WORDS); i++) gold[i] <= init_word(i);
    end else if (m_busy) begin
      if (cyc >= m_resp_from && rsp_ready_i) m_busy <= 1'b0;
    end else if (req_valid_i) begin
      m_busy <= 1'b1;
      m_we   <= req_we_i;
      m_wd   <= req_wdata_i;
      if (model_err(req_addr_i)) begin
        m_err       <= 1'b1;
        m_rdata     <= '0;
        m_issue     <= -1;
        m_resp_from <= cyc + 1;
      end else begin
        m_err       <= 1'b0;
        m_idx       <= word_of(req_addr_i);
        m_issue     <= cyc + 1;
        m_resp_from <= cyc + 2 + (req_we_i ? 0 : int'(LAT));
        if (req_we_i) begin
          gold[word_of(req_addr_i)] <= req_wdata_i;
          m_rdata <= '0;
        end else begin
          m_rdata <= gold[word_of(req_addr_i)];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      chk("req_ready", 32'(req_ready_o), 32'(!m_busy));
      chk("rsp_valid", 32'(rsp_valid_o), 32'(m_busy && cyc >= m_resp_from));
      chk("mem_we", 32'(mem_we_o), 32'(m_busy && cyc == m_issue && m_we));
      chk("mem_wd", mem_wd_o, (m_busy && cyc == m_issue) ? m_wd : 32'h0);
      if (m_busy && m_issue >= 0 && cyc >= m_issue && cyc < m_resp_from)
        chk("mem_addr", mem_addr_o, 32'(m_idx));
      if (m_busy && cyc >= m_resp_from) begin
        chk("rsp_rdata", rsp_rdata_o, m_rdata);
        chk("rsp_err", 32'(rsp_err_o), 32'(m_err));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1 while idle; returns at posedge+1 of the idle cycle after the response.
  task automatic txn(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                     input int hold, input bit junk);
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_wdata_i = wd;
    step();
    req_valid_i  = 1'b0;
    req_addr_i   = $urandom;
    req_wdata_i  = $urandom;
    rsp_ready_i  = 1'b0;
    t_lat        = 1;
    t_first_we   = mem_we_o;
    t_first_addr = mem_addr_o;
    t_first_wd   = mem_wd_o;
    t_any_we     = mem_we_o;
    while (!rsp_valid_o && t_lat < 12) begin
      step();
      t_lat++;
      t_any_we |= mem_we_o;
    end
    if (!rsp_valid_o) chk("rsp_timeout", 32'(rsp_valid_o), 32'h1);
    t_rd  = rsp_rdata_o;
    t_err = rsp_err_o;
    for (int h = 0; h < hold; h++) begin
      if (junk) begin
        req_valid_i = 1'b1;
        req_we_i    = 1'($urandom);
        req_addr_i  = rand_addr();
        req_wdata_i = $urandom;
      end
      step();
      chk("hold_valid", 32'(rsp_valid_o), 32'h1);
      chk("hold_rdata", rsp_rdata_o, t_rd);
      chk("hold_err", 32'(rsp_err_o), 32'(t_err));
      chk("hold_ready", 32'(req_ready_o), 32'h0);
      t_any_we |= mem_we_o;
    end
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    chk("idle_after_rsp", 32'(req_ready_o), 32'h1);
    chk("no_rsp_after", 32'(rsp_valid_o), 32'h0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(req_ready_o), 32'h1);
    chk({tag, "_valid"}, 32'(rsp_valid_o), 32'h0);
    chk({tag, "_err"}, 32'(rsp_err_o), 32'h0);
    chk({tag, "_rdata"}, rsp_rdata_o, 32'h0);
    chk({tag, "_mem_we"}, 32'(mem_we_o), 32'h0);
    chk({tag, "_mem_wd"}, mem_wd_o, 32'h0);
    chk({tag, "_mem_addr"}, mem_addr_o, 32'h0);
  endtask

  initial begin
    logic [31:0] bad [3];
    #1 rst_n = 1'b0;
    #1;
    chk_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    step();

    // Store then load of word 2.
    txn(1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 0, 1'b0);
    chk("st_lat", 32'(t_lat), 32'd2);
    chk("st_mem_we", 32'(t_first_we), 32'h1);
    chk("st_mem_addr", t_first_addr, 32'd2);
    chk("st_mem_wd", t_first_wd, 32'hDEAD_BEEF);
    chk("st_err", 32'(t_err), 32'h0);
    chk("st_rdata", t_rd, 32'h0);
    txn(1'b0, 32'h1001_0008, 32'h1234_5678, 0, 1'b0);
    chk("ld_lat", 32'(t_lat), 32'd3);
    chk("ld_any_we", 32'(t_any_we), 32'h0);
    chk("ld_rdata", t_rd, 32'hDEAD_BEEF);

    // Misaligned, just past the top, just below the base.
    bad[0] = 32'h1001_0002;
    bad[1] = 32'h1001_0100;
    bad[2] = 32'h1000_FFFC;
    for (int i = 0; i < 3; i++) begin
      txn(1'b0, bad[i], 32'h0, 0, 1'b0);
      chk("bad_err", 32'(t_err), 32'h1);
      chk("bad_rdata", t_rd, 32'h0);
      chk("bad_lat", 32'(t_lat), 32'd1);
      chk("bad_any_we", 32'(t_any_we), 32'h0);
    end

    // Top word with a stalled response and ignored requests meanwhile.
    txn(1'b1, 32'h1001_00FC, 32'hCAFE_F00D, 0, 1'b0);
    txn(1'b0, 32'h1001_00FC, 32'h0, 5, 1'b1);
    chk("top_lat", 32'(t_lat), 32'd3);
    chk("top_rdata", t_rd, 32'hCAFE_F00D);

    // Reset during WAIT aborts the load.
    req_valid_i = 1'b1;
    req_we_i    = 1'b0;
    req_addr_i  = 32'h1001_0010;
    step();
    req_valid_i = 1'b0;
    step();
    chk("pre_rst_valid", 32'(rsp_valid_o), 32'h0);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_no_rsp", 32'(rsp_valid_o), 32'h0);
    end
    txn(1'b1, 32'h1001_0010, 32'h0BAD_F00D, 0, 1'b0);
    chk("rst_st_lat", 32'(t_lat), 32'd2);
    chk("rst_st_addr", t_first_addr, 32'd4);
    txn(1'b0, 32'h1001_0010, 32'h0, 1, 1'b0);
    chk("rst_ld_rdata", t_rd, 32'h0BAD_F00D);

    // Randomized traffic, checked cycle by cycle against the model.
    for (int n = 0; n < 150; n++) begin
      repeat ($urandom_range(0, 2)) step();
      txn(1'($urandom), rand_addr(), $urandom, int'($urandom_range(0, 3)), 1'($urandom));
    end

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
